// File: rtl/hier_node_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hier_node_pkg
// Description : Shared constants, types and helpers for the hierarchy-node
//               collector. HIER_FANOUT/HIER_DATA_W are the default node shape.
//               rr_next() is the round-robin pointer wrap increment.
// Revision    : 1.0 - initial release
// ============================================================================
package hier_node_pkg;

    localparam int HIER_FANOUT = 10;
    localparam int HIER_DATA_W = 32;

    typedef logic [$clog2(HIER_FANOUT)-1:0] hier_idx_t;

    // Position after ptr in a ring of n entries (n-1 wraps to 0).
    function automatic int rr_next(input int ptr, input int n);
        return (ptr >= n - 1) ? 0 : ptr + 1;
    endfunction

endpackage : hier_node_pkg
`default_nettype wire

// File: rtl/hier_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : hier_rr_arbiter
// Description : Combinational rotate-priority picker. Searches req upward
//               starting at ptr, wrapping N-1 -> 0, and returns the first
//               requester.
// Ports       : req       [N]     request vector
//               ptr       [IDX_W] search start position (always < N)
//               grant     [N]     one-hot grant (zero when no request)
//               grant_idx [IDX_W] binary index of the granted requester
//               any                at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module hier_rr_arbiter #(
    parameter int N     = 10,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    int w_j;

    // Visit every position once, in rotated order; the first hit wins and
    // later hits are masked by 'any'.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        w_j       = 0;
        for (int k = 0; k < N; k++) begin
            w_j = (int'(ptr) + k) % N;
            if (!any && req[w_j]) begin
                any        = 1'b1;
                grant[w_j] = 1'b1;
                grant_idx  = IDX_W'(w_j);
            end
        end
    end

endmodule : hier_rr_arbiter
`default_nettype wire

// File: rtl/hier_node_collector.sv
`default_nettype none
// ============================================================================
// Module      : hier_node_collector
// Description : Merges NUM_CHILDREN child valid/ready streams into a single
//               registered upstream stream tagged with the source child index.
//               Round-robin arbitration; one beat per cycle when upstream is
//               ready.
// Ports       : clk, rst_n (async active-low)
//               child_valid/child_data/child_ready : per-child input streams
//               out_valid/out_data/out_idx/out_ready : upstream stream
//               busy : output beat pending or any child requesting
// Option      : HIER_COLLECTOR_STATS_EN adds stats_clr input and
//               beat_count/stall_count outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module hier_node_collector
    import hier_node_pkg::*;
#(
    parameter int NUM_CHILDREN = HIER_FANOUT,
    parameter int DATA_W       = HIER_DATA_W,
    parameter int IDX_W        = $clog2(NUM_CHILDREN)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CHILDREN-1:0]        child_valid,
    input  logic [NUM_CHILDREN*DATA_W-1:0] child_data,
    output logic [NUM_CHILDREN-1:0]        child_ready,
    output logic                           out_valid,
    output logic [DATA_W-1:0]              out_data,
    output logic [IDX_W-1:0]               out_idx,
    input  logic                           out_ready,
`ifdef HIER_COLLECTOR_STATS_EN
    input  logic                           stats_clr,
    output logic [31:0]                    beat_count,
    output logic [31:0]                    stall_count,
`endif
    output logic                           busy
);

    logic                    r_out_valid;
    logic [DATA_W-1:0]       r_out_data;
    logic [IDX_W-1:0]        r_out_idx;
    logic [IDX_W-1:0]        r_rr_ptr;

    logic                    w_load;
    logic [NUM_CHILDREN-1:0] w_grant;
    logic [IDX_W-1:0]        w_grant_idx;
    logic                    w_any;
    logic [DATA_W-1:0]       w_sel_data;

    hier_rr_arbiter #(
        .N     (NUM_CHILDREN),
        .IDX_W (IDX_W)
    ) u_arb (
        .req       (child_valid),
        .ptr       (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .any       (w_any)
    );

    // Output register is free, or is being emptied this cycle.
    assign w_load     = !r_out_valid || out_ready;
    assign w_sel_data = child_data[int'(w_grant_idx)*DATA_W +: DATA_W];

    // Held low during reset so no child believes a beat was taken.
    assign child_ready = (rst_n && w_load && w_any) ? w_grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_rr_ptr    <= '0;
        end else if (w_load) begin
            if (w_any) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_idx   <= w_grant_idx;
                r_rr_ptr    <= IDX_W'(rr_next(int'(w_grant_idx), NUM_CHILDREN));
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;
    assign busy      = r_out_valid | (|child_valid);

`ifdef HIER_COLLECTOR_STATS_EN
    logic [31:0] r_beat_count;
    logic [31:0] r_stall_count;

    // Beat counter wraps naturally; stall counter sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_count  <= '0;
            r_stall_count <= '0;
        end else if (stats_clr) begin
            r_beat_count  <= '0;
            r_stall_count <= '0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_beat_count <= r_beat_count + 32'd1;
            end
            if (r_out_valid && !out_ready && (r_stall_count != 32'hFFFF_FFFF)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign beat_count  = r_beat_count;
    assign stall_count = r_stall_count;
`endif

endmodule : hier_node_collector
`default_nettype wire

// File: tb/tb_hier_node_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_hier_node_collector
// Description : Directed self-checking bench for hier_node_collector with
//               10 children of 32-bit payload. Inputs change 1 time unit after
//               the rising edge; outputs are sampled there or 1 unit later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hier_node_collector;

    localparam int NC = 10;
    localparam int DW = 32;
    localparam int IW = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NC-1:0]    child_valid;
    logic [NC*DW-1:0] child_data;
    logic [NC-1:0]    child_ready;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic [IW-1:0]    out_idx;
    logic             out_ready;
    logic             busy;
`ifdef HIER_COLLECTOR_STATS_EN
    logic             stats_clr;
    logic [31:0]      beat_count;
    logic [31:0]      stall_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    hier_node_collector dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .child_valid (child_valid),
        .child_data  (child_data),
        .child_ready (child_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .out_ready   (out_ready),
`ifdef HIER_COLLECTOR_STATS_EN
        .stats_clr   (stats_clr),
        .beat_count  (beat_count),
        .stall_count (stall_count),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        child_valid = '0;
        child_data  = '0;
        out_ready   = 1'b0;
`ifdef HIER_COLLECTOR_STATS_EN
        stats_clr   = 1'b0;
`endif
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;

        // 1: idle after reset
        repeat (5) tick();
        chk("idle_out_valid",   32'(out_valid),   32'd0);
        chk("idle_child_ready", 32'(child_ready), 32'd0);
        chk("idle_busy",        32'(busy),        32'd0);
        chk("idle_out_idx",     32'(out_idx),     32'd0);
        chk("idle_out_data",    out_data,         32'd0);

        // 2: single child 3
        child_valid = 10'b00_0000_1000;
        child_data[3*DW +: DW] = 32'hA5A5_0003;
        out_ready = 1'b1;
        #1;
        chk("c3_child_ready", 32'(child_ready), 32'h008);
        chk("c3_busy",        32'(busy),        32'd1);
        tick();
        child_valid = '0;
        chk("c3_out_valid", 32'(out_valid), 32'd1);
        chk("c3_out_data",  out_data,       32'hA5A5_0003);
        chk("c3_out_idx",   32'(out_idx),   32'd3);
        tick();
        chk("c3_drain", 32'(out_valid), 32'd0);
        // pointer now 4: of children 2 and 5, child 5 must win
        child_valid = 10'b00_0010_0100;
        #1;
        chk("ptr4_grant", 32'(child_ready), 32'h020);
        // withdraw without handshake
        child_valid = '0;
        #1;
        chk("withdraw_ready", 32'(child_ready), 32'd0);
        tick();
        chk("withdraw_no_beat", 32'(out_valid), 32'd0);

        // 3: move pointer to 0 via child 9, then all children streaming
        for (int i = 0; i < NC; i++) child_data[i*DW +: DW] = 32'h1000_0000 + 32'(i);
        child_valid = 10'b10_0000_0000;
        tick();
        chk("c9_out_idx", 32'(out_idx), 32'd9);
        child_valid = '1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("rr_out_valid", 32'(out_valid), 32'd1);
            chk("rr_out_idx",   32'(out_idx),   32'(k % NC));
            chk("rr_out_data",  out_data,       32'h1000_0000 + 32'(k % NC));
        end
        child_valid = '0;
        tick();
        chk("rr_drain", 32'(out_valid), 32'd0);

        // 4: children 2 and 7 with upstream stall (pointer at 2)
        child_data[2*DW +: DW] = 32'h0000_0022;
        child_data[7*DW +: DW] = 32'h0000_0077;
        child_valid = 10'b00_1000_0100;
        out_ready = 1'b0;
        #1;
        chk("s_first_grant", 32'(child_ready), 32'h004);
        tick();
        child_valid = 10'b00_1000_0000;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("s_hold_ready", 32'(child_ready), 32'd0);
            chk("s_hold_idx",   32'(out_idx),     32'd2);
            chk("s_hold_data",  out_data,         32'h0000_0022);
            chk("s_hold_valid", 32'(out_valid),   32'd1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("s_release_ready", 32'(child_ready), 32'h080);
        tick();
        child_valid = '0;
        chk("s_next_idx",  32'(out_idx), 32'd7);
        chk("s_next_data", out_data,     32'h0000_0077);
        tick();

        // 5: reset mid-stream with beat idx 5 pending (pointer at 8)
        child_valid = 10'b00_0010_0000;
        out_ready = 1'b0;
        tick();
        chk("mid_idx5", 32'(out_idx), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid),   32'd0);
        chk("async_out_idx",   32'(out_idx),     32'd0);
        chk("async_ready",     32'(child_ready), 32'd0);
        tick();
        child_valid = 10'b00_0100_0001;
        child_data[0*DW +: DW] = 32'h0000_0A00;
        out_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_grant", 32'(child_ready), 32'h001);
        tick();
        chk("post_rst_idx",  32'(out_idx), 32'd0);
        chk("post_rst_data", out_data,     32'h0000_0A00);
        child_valid = '0;

`ifdef HIER_COLLECTOR_STATS_EN
        // 6: counters; first clear coincides with an output handshake
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        chk("clr_beat",  beat_count,  32'd0);
        chk("clr_stall", stall_count, 32'd0);
        child_valid = '1;
        repeat (10) tick();
        child_valid = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        chk("st_stall3", stall_count, 32'd3);
        chk("st_beat9",  beat_count,  32'd9);
        out_ready = 1'b1;
        tick();
        chk("st_beat10", beat_count,  32'd10);
        chk("st_stall",  stall_count, 32'd3);
        child_valid = 10'b00_0000_0010;
        tick();
        child_valid = '0;
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        chk("clr2_beat",  beat_count,  32'd0);
        chk("clr2_stall", stall_count, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_hier_node_collector
`default_nettype wire

// File: doc/hier_node_collector.md
Name: hier_node_collector

Overview:
- Aggregation stage that sits directly above each 10-way hierarchy node.
- Merges the per-child valid/ready streams from that node's NUM_CHILDREN child instances into one registered upstream stream.
- Tags each beat with the source child index.
- Fairness is round-robin, so no child instance can starve.

Parameters:
- NUM_CHILDREN, 10, number of child streams (2..16).
- DATA_W, 32, payload width per child.
- IDX_W, $clog2(NUM_CHILDREN), child index width. Derived; do not override.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- child_valid  input  NUM_CHILDREN  per-child beat valid.
- child_data  input  NUM_CHILDREN*DATA_W  packed payloads; child i occupies [i*DATA_W +: DATA_W].
- child_ready  output  NUM_CHILDREN  per-child accept; combinational, at most one bit high.
- out_valid  output  1  registered upstream valid.
- out_data  output  DATA_W  registered payload.
- out_idx  output  IDX_W  registered source child index.
- out_ready  input  1  upstream accept.
- busy  output  1  high when out_valid or any child_valid is high.

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - out_valid=0, out_data=0, out_idx=0.
  - rr_ptr=0; all child_ready=0.
- Handshake:
  - A transfer occurs on any edge where valid&&ready.
  - out_valid, once high, holds with stable out_data/out_idx until out_ready.
  - child_data is sampled only on its own child handshake.
- Load condition: load = !out_valid || out_ready, giving full throughput of 1 beat/cycle.
- Arbitration:
  - Grant goes to the first i with child_valid[i]=1, searching from rr_ptr upward with wrap at NUM_CHILDREN-1 -> 0.
  - child_ready[g] = load && (some child valid); all other child_ready bits = 0.
- On a grant edge:
  - out_data <= child_data[g]; out_idx <= g; out_valid <= 1.
  - rr_ptr <= (g==NUM_CHILDREN-1) ? 0 : g+1.
- Load with no child valid: out_valid <= 0 on that edge (drain); rr_ptr unchanged.
- Latency: child beat to out_valid is 1 cycle.
- Simultaneous out_ready and new grant in the same cycle: new beat replaces old with no bubble.
- child_valid dropped without a handshake is tolerated: arbitration re-evaluates every cycle and never locks.
- Reset mid-transfer: the pending output beat is discarded and rr_ptr returns to 0.
- busy = out_valid | (|child_valid).

Optional Feature:
- Macro: HIER_COLLECTOR_STATS_EN.
- When defined, adds outputs:
  - beat_count (32b): increments on every out handshake, wraps at 2^32-1 -> 0.
  - stall_count (32b): increments each cycle with out_valid && !out_ready, saturates at 2^32-1.
  - stats_clr input (1b): synchronous clear of both counters. Clear has priority over increment in the same cycle.
  - All three are reset to 0 by rst_n.
- When undefined: ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package hier_node_pkg holds:
  - localparam HIER_FANOUT = 10.
  - localparam HIER_DATA_W = 32.
  - typedef logic [$clog2(HIER_FANOUT)-1:0] hier_idx_t.
  - function rr_next(ptr, n) for the wrap increment.
- Sub-module hier_rr_arbiter holds the combinational rotate-priority pick (req, ptr -> grant one-hot, grant_idx, any).
- Register and counter logic stay in hier_node_collector.

Test Plan:
1. Reset release, all inputs idle, 5 cycles -> out_valid=0, child_ready=0, busy=0, out_idx=0.
2. Only child 3 valid with data 0xA5A5_0003, out_ready=1 -> child_ready[3] high that cycle; next cycle out_valid=1, out_data=0xA5A5_0003, out_idx=3; rr_ptr=4.
3. All 10 children continuously valid, out_ready=1 -> out_idx sequence 0,1,...,9,0,1; one beat per cycle, no bubbles.
4. Children 2 and 7 valid, out_ready held 0 for 4 cycles after the first beat:
   - out_idx=2 is held stable and all child_ready=0 during the stall.
   - On out_ready=1, the next beat is out_idx=7 in the following cycle.
5. rst_n pulsed low mid-stream while out_valid=1, idx=5 -> out_valid drops to 0 asynchronously; after release, a grant with children 0 and 6 valid selects 0.
6. With HIER_COLLECTOR_STATS_EN, run 10 beats plus 3 stall cycles:
   - beat_count=10, stall_count=3.
   - stats_clr asserted in the same cycle as a handshake -> both counters 0 next cycle.
